// File: rtl/arb_sink_fifo_pkg.sv
// Shared constants for the round-robin arbiter and its sink buffer.
// Default data width and buffer depth used by both sides of the link.
package arb_sink_fifo_pkg;

    localparam int ARB_W          = 1;
    localparam int ARB_SINK_DEPTH = 4;
    localparam int ARB_SINK_AW    = 2;

endpackage

// File: rtl/arb_sink_fifo_mem.sv
// Register-file storage for the arbiter sink buffer.
// One synchronous write port, one asynchronous read port, async reset.
module arb_sink_fifo_mem
    import arb_sink_fifo_pkg::*;
#(
    parameter int p_width = ARB_W,
    parameter int p_depth = ARB_SINK_DEPTH,
    parameter int p_aw    = ARB_SINK_AW
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_we,
    input  logic [p_aw-1:0]    i_waddr,
    input  logic [p_width-1:0] i_wdata,
    input  logic [p_aw-1:0]    i_raddr,
    output logic [p_width-1:0] o_rdata
);

    logic [p_width-1:0] mem_q [p_depth];
    logic [p_width-1:0] mem_d [p_depth];

    always_comb begin
        mem_d = mem_q;
        if (i_we) begin
            mem_d[i_waddr] = i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < p_depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/arb_sink_fifo.sv
// Sink buffer behind the 2-input round-robin arbiter: req/acc in,
// req/acc out, registered-only accept so the arbiter never sees i_acc.
module arb_sink_fifo
    import arb_sink_fifo_pkg::*;
#(
    parameter int p_width = ARB_W,
    parameter int p_depth = ARB_SINK_DEPTH,
    parameter int p_aw    = ARB_SINK_AW
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_req,
    input  logic [p_width-1:0] i_data,
    output logic               o_acc,
    output logic               o_req,
    output logic [p_width-1:0] o_data,
    input  logic               i_acc,
    output logic [p_aw:0]      o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam logic [p_aw:0]   lp_full = (p_aw+1)'(p_depth);
    localparam logic [p_aw:0]   lp_cone = (p_aw+1)'(1);
    localparam logic [p_aw-1:0] lp_pone = p_aw'(1);

    logic              r_rdy_q, r_rdy_d;
    logic [p_aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [p_aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [p_aw:0]     count_q, count_d;
    logic              push, pop;

    assign o_full  = (count_q == lp_full);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_req   = ~o_empty;

    // Accept depends on registered state only: a pop never frees a slot early.
    assign o_acc = i_req & r_rdy_q & ~o_full;
    assign push  = o_acc;
    assign pop   = o_req & i_acc;

    always_comb begin
        r_rdy_d  = 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + lp_pone;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + lp_pone;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + lp_cone;
            2'b01:   count_d = count_q - lp_cone;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_rdy_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            r_rdy_q  <= r_rdy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    arb_sink_fifo_mem #(
        .p_width (p_width),
        .p_depth (p_depth),
        .p_aw    (p_aw)
    ) u_mem (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_we    (push),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (o_data)
    );

endmodule
